// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the debouncer and related control blocks.
// Holds the 2-bit FSM state encodings and a constant-evaluable clog2.
package debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    PEND_LOW    = 2'b11
  } db_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = value - 1;
    while (rem != 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debouncer_synchronizer.sv
// Reusable multi-flop synchronizer for a single asynchronous level input.
// The last stage is the only output; all stages reset to RESET_LEVEL.
module synchronizer #(
  parameter int STAGES      = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign out = sync_q[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Switch/button debouncer: synchronizer followed by a four-state FSM that
// only accepts a new level after it has been held for DEBOUNCE_CYCLES cycles.
//
// state       | meaning
// STABLE_LOW  | out=0, sync_in agrees with out
// PEND_HIGH   | out=0, sync_in=1 being timed
// STABLE_HIGH | out=1, sync_in agrees with out
// PEND_LOW    | out=1, sync_in=0 being timed
module debouncer
  import debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic settling
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);
  // The edge that enters PEND is the first cycle of the hold, so the last
  // counted value before acceptance is DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam db_state_e RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  logic             sync_in;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             settling_q, settling_d;

  synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (sync_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE_LOW: begin
        if (sync_in) state_d = PEND_HIGH;
      end
      PEND_HIGH: begin
        if (!sync_in)              state_d = STABLE_LOW;
        else if (cnt_q == CNT_LAST) state_d = STABLE_HIGH;
        else                       cnt_d = cnt_q + 1'b1;
      end
      STABLE_HIGH: begin
        if (!sync_in) state_d = PEND_LOW;
      end
      PEND_LOW: begin
        if (sync_in)               state_d = STABLE_HIGH;
        else if (cnt_q == CNT_LAST) state_d = STABLE_LOW;
        else                       cnt_d = cnt_q + 1'b1;
      end
      default: state_d = RESET_STATE;
    endcase
    out_d      = (state_d == STABLE_HIGH) || (state_d == PEND_LOW);
    settling_d = (state_d == PEND_HIGH) || (state_d == PEND_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      out_q      <= RESET_LEVEL;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      settling_q <= settling_d;
    end
  end

  assign out      = out_q;
  assign settling = settling_q;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: fixed vector table, hand-written corner
// sequences and randomized runs against a run-length reference model.
module tb_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic in1 = 1'b1;
  logic out, settling, out1, settling1;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic m_pipe[S];
  logic m_out;
  int   m_run;

  typedef struct {
    logic in;
    int   hold;
    logic exp_out;
    logic exp_set;
  } vec_t;

  vec_t vecs[11];

  debouncer #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .settling(settling)
  );

  debouncer #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .out(out1), .settling(settling1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_pipe[i] = 1'b0;
    m_out = 1'b0;
    m_run = 0;
  endtask

  // A level is accepted once the FSM has seen it differ from out for D
  // consecutive edges; the FSM sees the raw input S edges late.
  task automatic model_edge(input logic v);
    logic seen;
    seen = m_pipe[S-1];
    for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = v;
    if (seen != m_out) begin
      m_run++;
      if (m_run == D) begin
        m_out = seen;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick(input logic v);
    in  = v;
    in1 = 1'b1;
    @(posedge clk);
    model_edge(v);
    #1;
    check("model_out", out, m_out);
    check("model_settling", settling, (m_run != 0));
    check("rl1_out", out1, 1'b1);
    check("rl1_settling", settling1, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4, 1'b0, 1'b0};

    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 1'b0);
    check("reset_settling", settling, 1'b0);
    check("reset_rl1_out", out1, 1'b1);
    check("reset_rl1_settling", settling1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // clean press, release and glitch
    for (int r = 0; r < 11; r++) begin
      for (int h = 0; h < vecs[r].hold; h++) tick(vecs[r].in);
      check($sformatf("vec%0d_out", r), out, vecs[r].exp_out);
      check($sformatf("vec%0d_settling", r), settling, vecs[r].exp_set);
    end
    check("glitch_cnt", dut.cnt_q, 0);

    // bounce, then a held press accepted exactly 6 edges after the last rise
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);
    check("bounce_out_low", out, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1);
      check($sformatf("bounce_edge%0d", k), out, (k == 6) ? 1'b1 : 1'b0);
    end
    repeat (8) tick(1'b0);
    check("bounce_release", out, 1'b0);

    // excursion of exactly D cycles is accepted, D-1 is not
    repeat (3) tick(1'b1);
    repeat (6) tick(1'b0);
    check("short_excursion", out, 1'b0);
    repeat (4) tick(1'b1);
    repeat (2) tick(1'b0);
    check("exact_excursion", out, 1'b1);
    repeat (8) tick(1'b0);
    check("exact_excursion_fall", out, 1'b0);

    // reset two cycles into PEND_HIGH aborts at once
    repeat (4) tick(1'b1);
    check("pre_reset_settling", settling, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset_out", out, 1'b0);
    check("async_reset_settling", settling, 1'b0);
    check("async_reset_cnt", dut.cnt_q, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1);
      check($sformatf("post_reset_edge%0d", k), out, (k == 6) ? 1'b1 : 1'b0);
    end

    // randomized runs against the model
    for (int r = 0; r < 300; r++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      repeat (len) tick(lvl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
